// File: rtl/sub_pipe_pkg.sv
// Shared types and arithmetic helpers for the pipelined add/subtract unit:
// 4-bit carry-lookahead groups and two's-complement overflow detection.
package sub_pipe_pkg;

  localparam int GRP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  typedef struct packed {
    logic [GRP_W-1:0] sum;
    grp_pg_t          pg;
  } grp_res_t;

  // Sum of one group for a given carry-in, plus the group propagate/generate
  // pair so the caller can chain groups without waiting on the sum.
  function automatic grp_res_t grp_lookahead(input logic [GRP_W-1:0] a,
                                             input logic [GRP_W-1:0] b,
                                             input logic             cin);
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] c;
    grp_res_t         res;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    for (int i = 0; i < GRP_W - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    res.sum  = p ^ c;
    res.pg.p = &p;
    res.pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
               (p[3] & p[2] & p[1] & g[0]);
    return res;
  endfunction

  // b_msb is the msb of the original (non-inverted) second operand.
  function automatic logic ovf_calc(input logic a_msb,
                                    input logic b_msb,
                                    input logic r_msb,
                                    input logic op_sub);
    logic ovf;
    if (op_sub) begin
      ovf = (a_msb != b_msb) & (r_msb != a_msb);
    end else begin
      ovf = (a_msb == b_msb) & (r_msb != a_msb);
    end
    return ovf;
  endfunction

endpackage

// File: rtl/sub_pipe_nbit_if.sv
// Operand/result bus of sub_pipe_nbit: one input handshake, one output handshake.
interface sub_pipe_nbit_if #(
  parameter int WIDTH = 16
);

  // Both channels use strict valid/ready: a transfer happens on a rising clk
  // edge where valid & ready are both 1; once valid is raised the payload
  // must stay stable until that transfer, and ready may depend on valid.
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, op_sub, din1, din2, out_ready,
    input  in_ready, out_valid, dout, bout, ovf
  );

  modport slave (
    input  in_valid, op_sub, din1, din2, out_ready,
    output in_ready, out_valid, dout, bout, ovf
  );

endinterface

// File: rtl/sub_pipe_stage.sv
// One registered slice: adds its G lookahead groups using the carry left by
// the previous slice, and carries the rest of the transaction along.
module sub_pipe_stage
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_r,
  input  logic             prev_c,
  input  logic             prev_op,
  output logic             v,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             op
);

  localparam int G  = WIDTH / (GRP_W * STAGES);
  localparam int LO = IDX * G * GRP_W;

  logic [WIDTH-1:0] r_next;
  logic             c_next;
  logic             cy;
  grp_res_t         res;

  // prev_b already holds ~din2 for subtraction, so every slice is a plain add.
  always_comb begin
    r_next = prev_r;
    cy     = prev_c;
    res    = '0;
    for (int j = 0; j < G; j++) begin
      res = grp_lookahead(prev_a[LO + j*GRP_W +: GRP_W],
                          prev_b[LO + j*GRP_W +: GRP_W], cy);
      r_next[LO + j*GRP_W +: GRP_W] = res.sum;
      cy = res.pg.g | (res.pg.p & cy);
    end
    c_next = cy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v  <= 1'b0;
      a  <= '0;
      b  <= '0;
      r  <= '0;
      c  <= 1'b0;
      op <= 1'b0;
    end else if (load) begin
      v <= prev_v;
      if (prev_v) begin
        a  <= prev_a;
        b  <= prev_b;
        r  <= r_next;
        c  <= c_next;
        op <= prev_op;
      end
    end
  end

endmodule

// File: rtl/sub_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract with valid/ready flow control and signed
// overflow flag. Define SUB_PIPE_SAT_EN to saturate dout on signed overflow.
module sub_pipe_nbit
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sub_pipe_nbit_if.slave bus
);

  if ((WIDTH % GRP_W) != 0 || (WIDTH / GRP_W) < STAGES ||
      ((WIDTH / GRP_W) % STAGES) != 0) begin : g_bad_cfg
    $error("sub_pipe_nbit: WIDTH/4 must be a positive multiple of STAGES");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] c_s;
  logic [STAGES-1:0] op_s;
  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];

  // Ready ripples back from the consumer so a full pipe still moves every
  // cycle that the output is taken.
  always_comb begin
    logic acc;
    acc = bus.out_ready | ~v[STAGES-1];
    rdy = '0;
    rdy[STAGES-1] = acc;
    for (int k = STAGES - 2; k >= 0; k--) begin
      acc    = ~v[k] | acc;
      rdy[k] = acc;
    end
  end

  assign bus.in_ready = rdy[0] & rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             pv;
    logic             pc;
    logic             pop;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] pr;

    if (k == 0) begin : g_first
      assign pv  = bus.in_valid;
      assign pa  = bus.din1;
      assign pb  = bus.din2 ^ {WIDTH{bus.op_sub}};
      assign pr  = '0;
      assign pc  = bus.op_sub;
      assign pop = bus.op_sub;
    end else begin : g_next
      assign pv  = v[k-1];
      assign pa  = a_s[k-1];
      assign pb  = b_s[k-1];
      assign pr  = r_s[k-1];
      assign pc  = c_s[k-1];
      assign pop = op_s[k-1];
    end

    sub_pipe_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (rdy[k]),
      .prev_v  (pv),
      .prev_a  (pa),
      .prev_b  (pb),
      .prev_r  (pr),
      .prev_c  (pc),
      .prev_op (pop),
      .v       (v[k]),
      .a       (a_s[k]),
      .b       (b_s[k]),
      .r       (r_s[k]),
      .c       (c_s[k]),
      .op      (op_s[k])
    );
  end

  logic             a_msb;
  logic             b_msb;
  logic             last_op;
  logic             ovf_w;
  logic [WIDTH-1:0] r_fin;

  always_comb begin
    last_op = op_s[STAGES-1];
    r_fin   = r_s[STAGES-1];
    a_msb   = a_s[STAGES-1][WIDTH-1];
    // Undo the subtract inversion to recover the original din2 sign.
    b_msb   = b_s[STAGES-1][WIDTH-1] ^ last_op;
    ovf_w   = ovf_calc(a_msb, b_msb, r_fin[WIDTH-1], last_op);

    bus.out_valid = v[STAGES-1];
    bus.bout      = last_op ? ~c_s[STAGES-1] : c_s[STAGES-1];
    bus.ovf       = ovf_w;
`ifdef SUB_PIPE_SAT_EN
    bus.dout      = ovf_w ? {a_msb, {(WIDTH-1){~a_msb}}} : r_fin;
`else
    bus.dout      = r_fin;
`endif
  end

endmodule

// File: tb/tb_sub_pipe_nbit.sv
// Scoreboard bench for sub_pipe_nbit (WIDTH=16, STAGES=4): directed corner
// cases, a stall/full scenario, a mid-flight reset and randomized traffic.
module tb_sub_pipe_nbit;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sub_pipe_nbit_if #(.WIDTH(WIDTH)) bus ();

  sub_pipe_nbit #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH+1:0] exp_q[$];
  int   xfer_q[$];
  bit   mon_en    = 0;
  bit   rec_en    = 0;
  bit   stall_en  = 0;
  int   stall_cnt = 0;
  bit   rnd_done  = 0;
  logic [WIDTH-1:0] corner [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the add/sub definitions.
  function automatic logic [WIDTH+1:0] model(input logic op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    int ua, ub, sa, sb, ur, sr;
    logic [WIDTH-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) begin
      ur = ua - ub;
      sr = sa - sb;
      bo = (ua < ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      bo = (ur > 65535);
    end
    d  = ur[WIDTH-1:0];
    ov = (sr > 32767) || (sr < -32768);
`ifdef SUB_PIPE_SAT_EN
    if (ov) d = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    return {d, bo, ov};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (stall_en && bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got dout=%0h expected no output", bus.dout);
        end else begin
          check("result", {bus.dout, bus.bout, bus.ovf}, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (rec_en) xfer_q.push_back(cyc);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    int t;
    bit acc;
    t   = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.din1     = a;
    bus.din2     = b;
    while (!acc && t < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        exp_q.push_back(model(op, a, b));
      end else begin
        t++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    return WIDTH'($urandom_range(0, 65535));
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF; corner[5] = 16'h8001;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.din1      = '0;
    bus.din2      = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_bout", bus.bout, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 0x1234 - 0x0034 with latency check
    send(1'b1, 16'h1234, 16'h0034);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_early", bus.out_valid, 0);
    end
    @(negedge clk);
    check("latency_4", bus.out_valid, 1);
    drain();

    // Borrow, signed-overflow subtract, overflow add, carry-out add
    send(1'b1, 16'h0000, 16'h0001);
    send(1'b1, 16'h8000, 16'h0001);
    send(1'b0, 16'h7FFF, 16'h0001);
    send(1'b0, 16'hFFFF, 16'h0001);
    idle();
    drain();

    // Eight back-to-back ops with the consumer stalled in cycles 3..7
    xfer_q.delete();
    stall_cnt = 0;
    rec_en    = 1;
    stall_en  = 1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
        end
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    rec_en   = 0;
    stall_en = 0;
    check("stall_xfer_count", xfer_q.size(), 8);
    check("stall_in_ready_low_cycles", stall_cnt, 4);
    if (xfer_q.size() > 0) check("stall_resume_span", xfer_q[$] - xfer_q[0], 7);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      send(1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
    end
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_in_ready_low", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_dout", bus.dout, 0);
    check("flush_bout", bus.bout, 0);
    check("flush_ovf", bus.ovf, 0);
    check("flush_in_ready", bus.in_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    // Randomized traffic with random gaps and random back-pressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        idle();
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
